// File: rtl/operand_loader.sv
// ----------------------------------------------------------------------------
// operand_loader
//   Assembles two 32-bit ALU operands (a, b) one byte at a time from an 8-bit
//   switch bank. Each press of the load button writes src into the byte
//   selected by byte_idx (0-3 -> a, 4-7 -> b). A press of the clear button
//   zeroes both operands and restarts the sequence.
//
//   Optional feature macro: DEBOUNCE_EN
//     When defined, each synchronized button passes through a debouncer that
//     only changes level after DEBOUNCE_CYCLES consecutive cycles of
//     disagreement. When undefined, no debounce logic exists.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   src            in   8   switch byte to write
//   btn_load       in   1   raw load push button (active high)
//   btn_clear      in   1   raw clear push button (active high)
//   a              out 32   assembled operand A
//   b              out 32   assembled operand B
//   byte_idx       out  3   index of the next byte to be written
//   load_strobe    out  1   one-cycle pulse per accepted byte write
//   operands_valid out  1   high while all 8 bytes are loaded
// ----------------------------------------------------------------------------
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  src,
    input  logic        btn_load,
    input  logic        btn_clear,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  byte_idx,
    output logic        load_strobe,
    output logic        operands_valid
);

    typedef enum logic {LOAD, READY} state_t;

    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [1:0]  r_ld_sync, r_clr_sync;
    logic [1:0]  r_init;
    logic        r_ld_arm, r_clr_arm;
    logic        w_ld_lvl, w_clr_lvl;
    logic        w_ld_evt, w_clr_evt;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_a, r_b;
    logic [2:0]  r_idx, w_idx_nxt;
    logic        r_strobe, w_strobe_nxt;
    logic        r_valid, w_valid_nxt;
    logic [63:0] w_ab;

    // Two-flop synchronizers plus a warm-up shift that marks when the second
    // stage holds a genuinely sampled button value rather than its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_sync  <= '0;
            r_clr_sync <= '0;
            r_init     <= '0;
        end else begin
            r_ld_sync  <= {r_ld_sync[0], btn_load};
            r_clr_sync <= {r_clr_sync[0], btn_clear};
            r_init     <= {r_init[0], 1'b1};
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_ld_cnt, r_clr_cnt;
    logic          r_ld_db, r_clr_db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt  <= '0;
            r_clr_cnt <= '0;
            r_ld_db   <= 1'b0;
            r_clr_db  <= 1'b0;
        end else begin
            if (r_ld_sync[1] != r_ld_db) begin
                if (r_ld_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_ld_db  <= r_ld_sync[1];
                    r_ld_cnt <= '0;
                end else begin
                    r_ld_cnt <= r_ld_cnt + CW'(1);
                end
            end else begin
                r_ld_cnt <= '0;
            end
            if (r_clr_sync[1] != r_clr_db) begin
                if (r_clr_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_clr_db  <= r_clr_sync[1];
                    r_clr_cnt <= '0;
                end else begin
                    r_clr_cnt <= r_clr_cnt + CW'(1);
                end
            end else begin
                r_clr_cnt <= '0;
            end
        end
    end

    assign w_ld_lvl  = r_ld_db;
    assign w_clr_lvl = r_clr_db;
`else
    assign w_ld_lvl  = r_ld_sync[1];
    assign w_clr_lvl = r_clr_sync[1];
`endif

    // Edge register: "armed" means the button has been genuinely seen low
    // since the last event, so a button held through reset release stays
    // disarmed until it is released and pressed again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_arm  <= 1'b0;
            r_clr_arm <= 1'b0;
        end else begin
            if (w_ld_lvl)
                r_ld_arm <= 1'b0;
            else if (r_init[1] && !r_ld_sync[1])
                r_ld_arm <= 1'b1;
            if (w_clr_lvl)
                r_clr_arm <= 1'b0;
            else if (r_init[1] && !r_clr_sync[1])
                r_clr_arm <= 1'b1;
        end
    end

    assign w_ld_evt  = w_ld_lvl  & r_ld_arm;
    assign w_clr_evt = w_clr_lvl & r_clr_arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LOAD;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_strobe <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_ab[31:0];
            r_b      <= w_ab[63:32];
            r_idx    <= w_idx_nxt;
            r_strobe <= w_strobe_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    // Operands are handled as one 64-bit word {b, a} so byte_idx directly
    // selects the byte lane.
    always_comb begin
        w_state_nxt  = r_state;
        w_ab         = {r_b, r_a};
        w_idx_nxt    = r_idx;
        w_strobe_nxt = 1'b0;
        w_valid_nxt  = r_valid;
        if (w_clr_evt) begin
            w_state_nxt = LOAD;
            w_ab        = '0;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else if (w_ld_evt) begin
            w_strobe_nxt = 1'b1;
            case (r_state)
                LOAD: begin
                    w_ab[{r_idx, 3'b000} +: 8] = src;
                    if (r_idx == 3'd7) begin
                        w_idx_nxt   = '0;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = READY;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
                READY: begin
                    w_ab[7:0]   = src;
                    w_idx_nxt   = 3'd1;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = LOAD;
                end
                default: w_state_nxt = LOAD;
            endcase
        end
    end

    assign a              = r_a;
    assign b              = r_b;
    assign byte_idx       = r_idx;
    assign load_strobe    = r_strobe;
    assign operands_valid = r_valid;

endmodule
